uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that turns a parallel byte into an asynchronous serial frame: one start bit, LSB-first data, optional even parity, and one stop bit. It is the transmit end of the team's serial link and pairs with a receiver that samples the same frame format. Upstream logic hands it a word through a valid/ready handshake, and `tx_out` drives the line directly.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥ 1.

- `clk`  input  1: sole clock; all state updates on posedge.
- `rst`  input  1: asynchronous, active-high reset.
- `data_in`  input  DATA_W: word to transmit; sampled only on the acceptance edge.
- `valid_in`  input  1: upstream has a word.
- `ready_out`  output  1: transmitter can accept a word this cycle.
- `tx_out`  output  1: serial line; idles high.
- `busy_out`  output  1: a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY exists only when `UART_TX_PARITY_EN` is defined.
- Reset values: `tx_out`=1, `ready_out`=1, `busy_out`=0, state=IDLE, all counters 0.
- Acceptance happens on a posedge with `valid_in` & `ready_out`.
  - `data_in` is latched into a shift register.
  - State goes IDLE→START.
- `ready_out` = 1 only in IDLE. `busy_out` = 1 in every other state.
- START: `tx_out`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx_out` = shift-register bit 0. The register shifts right every CLKS_PER_BIT cycles. After DATA_W bits, go to PARITY (if enabled) or STOP.
- PARITY: `tx_out` = XOR of the latched word (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles, then IDLE.
- Bit-time counter: width clog2(CLKS_PER_BIT), minimum 1. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Bit index counter: width clog2(DATA_W). It is cleared on entry to DATA.
- `valid_in` while busy is ignored. Nothing is queued and the frame in flight is unaffected.
- Changes to `data_in` after acceptance have no effect on the frame in flight.
- Reset mid-frame:
  - `tx_out` returns to 1 immediately (asynchronous) and the frame is abandoned.
  - After reset release, the block sits in IDLE with `ready_out`=1.
  - No resumption of the abandoned frame.

## Timing
- All outputs are registered. `tx_out` never glitches, including between bits.
- If the acceptance edge is cycle 0:
  - `tx_out` falls (start bit) at cycle 1; `ready_out` and `busy_out` change at the same edge.
  - Data bit k occupies cycles 1+(k+1)·CLKS_PER_BIT .. 1+(k+2)·CLKS_PER_BIT−1.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles, or (DATA_W+3)·CLKS_PER_BIT with parity.
- `ready_out` rises on the edge that ends STOP.
- With `valid_in` held high, the next acceptance happens on the following edge. The minimum inter-frame gap is therefore 1 idle cycle with `tx_out`=1.
- CLKS_PER_BIT=1 is legal and gives one cycle per bit.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is present and an even-parity bit follows the MSB.
- Undefined: PARITY is removed entirely and DATA goes directly to STOP.
- No port changes in either case.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - `UART_IDLE_LEVEL`=1, `UART_START_LEVEL`=0;
  - the default CLKS_PER_BIT.
- The receiver imports the same package so both ends agree on frame format.
- One sub-module: `uart_baud_tick`, the bit-time counter. It has inputs `clk`, `rst`, `clear_in` and output `tick_out`. `tick_out` pulses on the last cycle of each bit.
- The FSM, shift register and bit index live in `uart_tx`.

## Test plan
All scenarios use DATA_W=8 and CLKS_PER_BIT=4.
1. Reset: `rst`=1 with `clk` running → `tx_out`=1, `ready_out`=1, `busy_out`=0. Holds after release with `valid_in`=0.
2. Single frame: `data_in`=8'hA5, `valid_in`=1 for one cycle → `tx_out` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). `busy_out`=1 throughout; `ready_out` returns to 1 on cycle 41.
3. Ignore while busy: during the 8'hA5 frame, pulse `valid_in` with 8'h3C → A5 waveform unchanged and no second frame follows.
4. Back-to-back: hold `valid_in`=1, sending 8'h00 then 8'hFF → two complete frames separated by exactly 1 idle cycle of `tx_out`=1.
5. Reset mid-frame: assert `rst` during data bit 3 of 8'hA5 → `tx_out`=1 before the next edge. After release, `ready_out`=1 and the line stays high.
6. Parity (`UART_TX_PARITY_EN` defined):
   - 8'hA5 → parity bit 0, frame length 44 cycles.
   - 8'h07 → parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame-format definitions shared by the serial transmitter and receiver.
// State encoding, line levels and the default bit time live here so that both
// ends of the link agree on the frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time counter for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps on each bit boundary;
// tick_out marks the last cycle of every bit. clear_in holds the count at 0.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold at zero while cleared, wrap after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_in || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_out = (cnt_q == CNT_LAST) && !clear_in;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter (start bit, LSB-first data,
// optional even parity, one stop bit) fed through a valid/ready handshake.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the MSB; without it DATA goes straight to STOP.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | line high, ready for a word
// ST_START  | start bit (line low) for one bit time
// ST_DATA   | shift out DATA_W bits, LSB first
// ST_PARITY | even parity of the latched word (macro only)
// ST_STOP   | stop bit (line high) for one bit time
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy_out
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              bit_tick;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_in(state_q == ST_IDLE),
    .tick_out(bit_tick)
  );

  // Frame sequencer: state, shift register, bit index and registered line/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in && ready_q) begin
            shift_q  <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^data_in;
`endif
            tx_q     <= UART_START_LEVEL;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= ST_STOP;
`endif
            end else begin
              // Line follows the bit that becomes shift_q[0] after this shift.
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            tx_q    <= UART_IDLE_LEVEL;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_out    = tx_q;
  assign ready_out = ready_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (DATA_W=8, CLKS_PER_BIT=4).
// Expected line levels per frame are hand-computed bit lists (start, data LSB
// first, optional parity, stop), expanded to one entry per clock cycle.
module tb_uart_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic              tx_out;
  logic              busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .tx_out   (tx_out),
    .busy_out (busy_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Select the hand-computed level list for the current build.
  function automatic logic [10:0] lvls(input logic [9:0] no_par, input logic [10:0] with_par);
`ifdef UART_TX_PARITY_EN
    return with_par;
`else
    return {1'b0, no_par};
`endif
  endfunction

  // One entry per cycle: level i repeated CPB times.
  function automatic logic [63:0] expand(input logic [10:0] lv);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < CPB; j++)
        w[i*CPB+j] = lv[i];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one acceptance edge; afterwards data_in is scrambled.
  task automatic accept(input logic [7:0] d);
    data_in  = d;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    data_in  = 8'h5A;
  endtask

  // Record FL cycles of the line starting at frame cycle 1; optionally pulse valid_in mid-frame.
  task automatic capture(input int poke_at, input logic [7:0] poke_data,
                         output logic [63:0] wave, output logic busy_all, output logic ready_any);
    wave      = '0;
    busy_all  = 1'b1;
    ready_any = 1'b0;
    for (int c = 0; c < FL; c++) begin
      wave[c]   = tx_out;
      busy_all  = busy_all & busy_out;
      ready_any = ready_any | ready_out;
      if (poke_at >= 0 && c == poke_at) begin
        valid_in = 1'b1;
        data_in  = poke_data;
      end else if (poke_at >= 0 && c == poke_at + 1) begin
        valid_in = 1'b0;
      end
      step();
    end
  endtask

  // Watch an idle stretch: line must stay high, ready high, busy low.
  task automatic idle_watch(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      ok = ok & tx_out & ready_out & ~busy_out;
      step();
    end
    check(tag, {63'd0, ok}, 64'd1);
  endtask

  logic [63:0] w;
  logic        b_all;
  logic        r_any;

  initial begin
    // 1. Reset
    step(); step(); step();
    check("rst_tx", {63'd0, tx_out}, 64'd1);
    check("rst_ready", {63'd0, ready_out}, 64'd1);
    check("rst_busy", {63'd0, busy_out}, 64'd0);
    rst = 1'b0;
    idle_watch("post_rst_idle", 5);

    // 2. Single frame A5
    accept(8'hA5);
    capture(-1, 8'h00, w, b_all, r_any);
    check("a5_wave", w, expand(lvls(10'h34A, 11'h54A)));
    check("a5_busy", {63'd0, b_all}, 64'd1);
    check("a5_ready_low", {63'd0, r_any}, 64'd0);
    check("a5_end_ready", {63'd0, ready_out}, 64'd1);
    check("a5_end_busy", {63'd0, busy_out}, 64'd0);
    check("a5_end_tx", {63'd0, tx_out}, 64'd1);

    // 3. valid_in during a frame is ignored
    accept(8'hA5);
    capture(8, 8'h3C, w, b_all, r_any);
    check("ign_wave", w, expand(lvls(10'h34A, 11'h54A)));
    check("ign_busy", {63'd0, b_all}, 64'd1);
    idle_watch("ign_no_second", 12);

    // 4. Back-to-back with valid_in held high: 00 then FF
    data_in  = 8'h00;
    valid_in = 1'b1;
    step();
    data_in  = 8'hFF;
    capture(-1, 8'h00, w, b_all, r_any);
    check("b2b_wave0", w, expand(lvls(10'h200, 11'h400)));
    check("b2b_busy0", {63'd0, b_all}, 64'd1);
    check("b2b_gap_tx", {63'd0, tx_out}, 64'd1);
    check("b2b_gap_ready", {63'd0, ready_out}, 64'd1);
    check("b2b_gap_busy", {63'd0, busy_out}, 64'd0);
    step();
    valid_in = 1'b0;
    capture(-1, 8'h00, w, b_all, r_any);
    check("b2b_wave1", w, expand(lvls(10'h3FE, 11'h5FE)));
    check("b2b_busy1", {63'd0, b_all}, 64'd1);
    check("b2b_end_ready", {63'd0, ready_out}, 64'd1);

    // 5. Reset during data bit 3 (cycles 17..20) of A5; bit 3 of A5 is 0
    accept(8'hA5);
    for (int c = 1; c < 18; c++) step();
    check("mid_bit3_level", {63'd0, tx_out}, 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {63'd0, tx_out}, 64'd1);
    check("mid_rst_ready", {63'd0, ready_out}, 64'd1);
    check("mid_rst_busy", {63'd0, busy_out}, 64'd0);
    step(); step();
    rst = 1'b0;
    idle_watch("mid_post_idle", 50);

    // 6. Frame for 07 (three ones: parity bit 1 when enabled)
    accept(8'h07);
    capture(-1, 8'h00, w, b_all, r_any);
    check("w07_wave", w, expand(lvls(10'h20E, 11'h60E)));
    check("w07_ready_low", {63'd0, r_any}, 64'd0);
    check("w07_end_ready", {63'd0, ready_out}, 64'd1);
`ifdef UART_TX_PARITY_EN
    check("w07_parity_bit", {63'd0, w[9*CPB]}, 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
